game_sequencer: RTL and testbench

Run-level controller for the dot-runner game. It sequences the scroll datapath through ready, run and game-over phases and generates the scroll `tick` from a programmable period. It also detects runner/obstacle collisions, keeps the score, and optionally shortens the scroll period as play continues. It sits between the KEY inputs and the scroll datapath, and replaces the free-running countdown inside the datapath.

---
 rtl/game_pkg.sv | 18 +
 rtl/game_sequencer_tick_timer.sv | 41 ++++
 rtl/game_sequencer.sv | 147 ++++++++++++++
 tb/tb_game_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and widths for the dot-runner game sequencer.
package game_pkg;

  localparam int RATE_W   = 28;
  localparam int SCORE_W  = 16;
  localparam int HEIGHT_W = 7;

  typedef enum logic [1:0] {
    READY = 2'd0,
    RUN   = 2'd1,
    OVER  = 2'd2
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + {{(SCORE_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/game_sequencer_tick_timer.sv
// Loadable scroll-period down-counter; zero is a registered one-cycle strobe
// raised on the cycle after the count reaches 0 while enabled.
module tick_timer
  import game_pkg::*;
#(
  parameter logic [RATE_W-1:0] INIT_VAL = 28'd3_000_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [RATE_W-1:0] load_val,
  input  logic              en,
  output logic              zero
);

  logic [RATE_W-1:0] count_q;
  logic              zero_q;

  // Countdown with reload on zero; an explicit load takes priority.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= INIT_VAL;
      zero_q  <= 1'b0;
    end else begin
      zero_q <= 1'b0;
      if (load) begin
        count_q <= load_val;
      end else if (en) begin
        if (count_q == {RATE_W{1'b0}}) begin
          count_q <= load_val;
          zero_q  <= 1'b1;
        end else begin
          count_q <= count_q - {{(RATE_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/game_sequencer.sv
// Run-level controller: READY/RUN/OVER sequencing, scroll tick, collision and score.
// Optional period ramp enabled by defining GAME_SEQUENCER_SPEEDUP_EN.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned RATE_INIT     = 3_000_000,
  parameter int unsigned RATE_MIN      = 750_000,
  parameter int unsigned RATE_STEP     = 150_000,
  parameter int unsigned SPEEDUP_EVERY = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic                stop,
  input  logic [HEIGHT_W-1:0] runner_height,
  input  logic [1:0]          obstacle_head,
  output logic                start,
  output logic                move,
  output logic                tick,
  output logic [RATE_W-1:0]   rate,
  output logic [SCORE_W-1:0]  score,
  output logic                game_over
);

  localparam logic [RATE_W-1:0] RATE_INIT_C = RATE_W'(RATE_INIT);

  if (SPEEDUP_EVERY < 1 || SPEEDUP_EVERY > 255 || RATE_MIN > RATE_INIT ||
      RATE_STEP > RATE_INIT) begin : g_bad_cfg
    $error("game_sequencer: invalid rate/speed-up parameters");
  end

  state_e             state_q;
  logic               start_q, move_q, game_over_q, tick_d_q;
  logic [SCORE_W-1:0] score_q;
  logic [RATE_W-1:0]  rate_q;

  logic              tick_s, hit_s, clean_s, in_run_s, exit_s;
  logic              timer_load_s, timer_en_s;
  logic [RATE_W-1:0] load_val_s;

  // Datapath has settled one cycle after tick, so the collision is judged on tick_d.
  assign hit_s        = (obstacle_head != 2'd0) &&
                        (runner_height <= {{(HEIGHT_W-2){1'b0}}, obstacle_head});
  assign in_run_s     = (state_q == RUN);
  assign clean_s      = in_run_s && tick_d_q && !hit_s;
  assign exit_s       = in_run_s && (stop || (tick_d_q && hit_s));
  assign timer_load_s = (state_q == READY) && go;
  assign timer_en_s   = in_run_s && !exit_s;
  assign load_val_s   = timer_load_s ? RATE_INIT_C : rate_q;

  tick_timer #(.INIT_VAL(RATE_INIT_C)) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (timer_load_s),
    .load_val (load_val_s),
    .en       (timer_en_s),
    .zero     (tick_s)
  );

`ifdef GAME_SEQUENCER_SPEEDUP_EN
  localparam logic [RATE_W-1:0] RATE_MIN_C  = RATE_W'(RATE_MIN);
  localparam logic [RATE_W-1:0] RATE_STEP_C = RATE_W'(RATE_STEP);
  localparam logic [7:0]        SPD_LAST_C  = 8'(SPEEDUP_EVERY - 1);

  logic [7:0]        spd_cnt_q;
  logic              spd_wrap_s;
  logic [RATE_W-1:0] rate_dec_s;

  // Compare in RATE_W+1 bits so STEP+MIN cannot wrap.
  assign spd_wrap_s = (spd_cnt_q == SPD_LAST_C);
  assign rate_dec_s = ({1'b0, rate_q} >= ({1'b0, RATE_STEP_C} + {1'b0, RATE_MIN_C})) ?
                      (rate_q - RATE_STEP_C) : RATE_MIN_C;

  // Clean-tick counter between speed-ups.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      spd_cnt_q <= 8'd0;
    end else if (timer_load_s) begin
      spd_cnt_q <= 8'd0;
    end else if (clean_s) begin
      spd_cnt_q <= spd_wrap_s ? 8'd0 : spd_cnt_q + 8'd1;
    end
  end
`endif

  // Run-level FSM with registered phase outputs, score and rate.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= READY;
      start_q     <= 1'b1;
      move_q      <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= {SCORE_W{1'b0}};
      rate_q      <= RATE_INIT_C;
      tick_d_q    <= 1'b0;
    end else begin
      tick_d_q <= tick_s;
      case (state_q)
        READY: begin
          if (go) begin
            state_q <= RUN;
            start_q <= 1'b0;
            move_q  <= 1'b1;
            score_q <= {SCORE_W{1'b0}};
            rate_q  <= RATE_INIT_C;
          end
        end
        RUN: begin
          if (clean_s) begin
            score_q <= sat_inc(score_q);
`ifdef GAME_SEQUENCER_SPEEDUP_EN
            if (spd_wrap_s) begin
              rate_q <= rate_dec_s;
            end
`endif
          end
          if (exit_s) begin
            state_q     <= OVER;
            move_q      <= 1'b0;
            game_over_q <= 1'b1;
          end
        end
        OVER: begin
          if (go) begin
            state_q     <= READY;
            game_over_q <= 1'b0;
            start_q     <= 1'b1;
          end
        end
        default: begin
          state_q     <= READY;
          start_q     <= 1'b1;
          move_q      <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign start     = start_q;
  assign move      = move_q;
  assign tick      = tick_s;
  assign rate      = rate_q;
  assign score     = score_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with RATE_INIT=4, RATE_MIN=2, RATE_STEP=1, SPEEDUP_EVERY=2.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        resetn, go, stop;
  logic [6:0]  runner_height;
  logic [1:0]  obstacle_head;
  logic        start, move, tick, game_over;
  logic [27:0] rate;
  logic [15:0] score;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .RATE_INIT(4), .RATE_MIN(2), .RATE_STEP(1), .SPEEDUP_EVERY(2)
  ) dut (
    .clk(clk), .resetn(resetn), .go(go), .stop(stop),
    .runner_height(runner_height), .obstacle_head(obstacle_head),
    .start(start), .move(move), .tick(tick), .rate(rate),
    .score(score), .game_over(game_over)
  );

`ifdef GAME_SEQUENCER_SPEEDUP_EN
  localparam bit SPD = 1'b1;
`else
  localparam bit SPD = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Step until tick is seen (bounded) and check the number of cycles taken.
  task automatic wait_tick(input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 40);
    chk(tag, n, exp_n);
  endtask

  initial begin
    int ticks_seen;
    resetn = 1'b0; go = 1'b0; stop = 1'b0;
    runner_height = 7'd10; obstacle_head = 2'd0;
    step(); step();
    chk("rst_start", start, 1);
    chk("rst_move", move, 0);
    chk("rst_tick", tick, 0);
    chk("rst_over", game_over, 0);
    chk("rst_score", score, 0);
    chk("rst_rate", rate, 4);
    resetn = 1'b1;

    // Start a game and follow clean ticks through the speed-up ramp.
    go = 1'b1; step(); go = 1'b0;
    chk("run_move", move, 1);
    chk("run_start", start, 0);
    chk("run_score0", score, 0);
    wait_tick("tick1_at_5", 5);
    step(); step();
    chk("score1", score, 1);
    wait_tick("tick2", 3);
    step(); step();
    chk("score2", score, 2);
    chk("rate_after2", rate, SPD ? 3 : 4);
    wait_tick("tick3", 3);
    step(); step();
    chk("score3", score, 3);
    chk("over_clean", game_over, 0);
    obstacle_head = 2'd2; runner_height = 7'd3;
    wait_tick("tick4", SPD ? 2 : 3);
    step(); step();
    chk("score4_nohit", score, 4);
    chk("rate_after4", rate, SPD ? 2 : 4);
    wait_tick("tick5", SPD ? 2 : 3);
    step(); step();
    chk("score5", score, 5);
    wait_tick("tick6", SPD ? 1 : 3);
    step(); step();
    chk("score6", score, 6);
    chk("rate_floor", rate, SPD ? 2 : 4);

    // Collision: runner at or below obstacle height.
    runner_height = 7'd1;
    wait_tick("tick7", SPD ? 1 : 3);
    step();
    chk("hit_over_t1", game_over, 0);
    step();
    chk("hit_over_t2", game_over, 1);
    chk("hit_score", score, 6);
    chk("hit_move", move, 0);
    ticks_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick === 1'b1) ticks_seen++;
    end
    chk("no_tick_over", ticks_seen, 0);
    chk("over_rate_hold", rate, SPD ? 2 : 4);

    // go in OVER returns to READY holding score; second go clears it.
    obstacle_head = 2'd0; runner_height = 7'd10;
    go = 1'b1; step(); go = 1'b0;
    chk("ready_start", start, 1);
    chk("ready_over", game_over, 0);
    chk("ready_score", score, 6);
    go = 1'b1; step(); go = 1'b0;
    chk("rerun_move", move, 1);
    chk("rerun_score", score, 0);
    chk("rerun_rate", rate, 4);

    // stop on the cycle the timer hits 0: no tick on the exit cycle.
    step(); step(); step(); step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_exit_tick", tick, 0);
    chk("stop_over", game_over, 1);
    step();
    chk("stop_after_tick", tick, 0);

    // stop together with a hit: OVER, no score increment.
    go = 1'b1; step(); go = 1'b0;
    go = 1'b1; step(); go = 1'b0;
    wait_tick("sh_tick1", 5);
    step(); step();
    chk("sh_score1", score, 1);
    wait_tick("sh_tick2", 3);
    step();
    stop = 1'b1; obstacle_head = 2'd2; runner_height = 7'd1;
    step();
    stop = 1'b0; obstacle_head = 2'd0; runner_height = 7'd10;
    chk("sh_over", game_over, 1);
    chk("sh_score", score, 1);

    // Reset in the middle of a run.
    go = 1'b1; step(); go = 1'b0;
    go = 1'b1; step(); go = 1'b0;
    wait_tick("mr_tick", 5);
    step(); step();
    chk("mr_score_pre", score, 1);
    resetn = 1'b0; step(); resetn = 1'b1;
    chk("mr_start", start, 1);
    chk("mr_move", move, 0);
    chk("mr_score", score, 0);
    chk("mr_rate", rate, 4);

    // stop ignored in READY; go wins over stop.
    stop = 1'b1; step();
    chk("ready_stop_start", start, 1);
    chk("ready_stop_move", move, 0);
    go = 1'b1; step(); go = 1'b0; stop = 1'b0;
    chk("go_wins_move", move, 1);
    chk("go_wins_over", game_over, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
